// File: rtl/tt_lut_pkg.sv
// Shared types and limits for the truth-table LUT evaluator.
package tt_lut_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam int MIN_N_IN = 2;
    localparam int MAX_N_IN = 6;

endpackage

// File: rtl/tt_lut_loader.sv
// Serial truth-table loader: RUN/LOAD state machine, bit counter and table register(s).
// With TT_LUT_SHADOW_EN, bits land in a shadow table copied to the active one on cfg_done.
module tt_lut_loader
    import tt_lut_pkg::*;
#(
    parameter int                  N_IN    = 4,
    parameter logic [2**N_IN-1:0]  TT_INIT = 16'hA960
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_done,
    output state_t               state,
    output logic [2**N_IN-1:0]   tt_active
);

    localparam int              W        = 2**N_IN;
    localparam logic [N_IN:0]   LAST_CNT = (N_IN+1)'(W - 1);

    state_t          state_nxt;
    logic            shift_en;
    logic            load_last;
    logic [N_IN:0]   bit_cnt;

    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_start) state_nxt = LOAD;
            LOAD:    if (cfg_start)      state_nxt = LOAD;
                     else if (load_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        shift_en  = 1'b0;
        load_last = 1'b0;
        if (state == LOAD && !cfg_start && cfg_valid) begin
            shift_en  = 1'b1;
            load_last = (bit_cnt == LAST_CNT);
        end
    end

    // A restart (cfg_start) wins over a bit arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= load_last;
            if (cfg_start)     bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
        end
    end

`ifdef TT_LUT_SHADOW_EN
    logic [W-1:0] tt_shadow;

    // NOTE: the shadow is fully overwritten before any copy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (shift_en) tt_shadow <= {tt_shadow[W-2:0], cfg_bit};
    end

    always_ff @(posedge clk) begin
        if (rst)           tt_active <= TT_INIT;
        else if (cfg_done) tt_active <= tt_shadow;
    end
`else
    always_ff @(posedge clk) begin
        if (rst)           tt_active <= TT_INIT;
        else if (shift_en) tt_active <= {tt_active[W-2:0], cfg_bit};
    end
`endif

endmodule

// File: rtl/tt_lut_eval.sv
// Truth-table function evaluator with valid/ready handshakes and a serial table loader.
// Optional macro TT_LUT_SHADOW_EN: load into a shadow table so evaluation continues during LOAD.
module tt_lut_eval
    import tt_lut_pkg::*;
#(
    parameter int                  N_IN    = 4,
    parameter logic [2**N_IN-1:0]  TT_INIT = 16'hA960
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data
);

    localparam int W = 2**N_IN;

    state_t           state;
    logic [W-1:0]     tt_active;
    logic             run_ok;
    logic             accept;
    logic [N_IN-1:0]  tt_idx;

    tt_lut_loader #(
        .N_IN    (N_IN),
        .TT_INIT (TT_INIT)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_done  (cfg_done),
        .state     (state),
        .tt_active (tt_active)
    );

    // A load request in RUN always takes priority over an operand that cycle.
`ifdef TT_LUT_SHADOW_EN
    assign run_ok = !(state == RUN && cfg_start);
`else
    assign run_ok = (state == RUN) && !cfg_start;
`endif

    assign in_ready = run_ok && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // MSB-first table: index W-1-idx is simply the bitwise complement of idx.
    assign tt_idx = ~in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= tt_active[tt_idx];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/tt_lut_eval.md
TT_LUT_EVAL -- requirements
Module: tt_lut_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of truth-table inputs, legal range 2..6.
REQ-002 SHALL have parameter TT_INIT, width 2**N_IN, default 16'hA960: truth table loaded at reset.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_start, input, 1: begins a table load.
REQ-006 SHALL have port cfg_valid, input, 1: cfg_bit is valid this cycle.
REQ-007 SHALL have port cfg_bit, input, 1: serial table bit, MSB (TT[2**N_IN-1]) first.
REQ-008 SHALL have port cfg_done, output, 1: one-cycle pulse when the load completes.
REQ-009 SHALL have port in_valid, input, 1; in_ready, output, 1: input handshake.
REQ-010 SHALL have port in_data, input, N_IN: operand vector; in_data[0] is the index LSB.
REQ-011 SHALL have port out_valid, input, 1... corrected: out_valid, output, 1; out_ready, input, 1: output handshake.
REQ-012 SHALL have port out_data, output, 1: evaluated function bit.

Function
REQ-013 SHALL compute out_data = TT[2**N_IN-1-idx], where idx = unsigned in_data (MSB-first table convention).
REQ-014 SHALL accept an operand when in_valid && in_ready, with the result valid exactly 1 cycle later (registered output).
REQ-015 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready), which gives full throughput under no backpressure.
REQ-016 SHALL hold out_data/out_valid stable while out_valid && !out_ready.
REQ-017 SHALL implement states RUN and LOAD: cfg_start in RUN moves to LOAD and clears the bit counter; when 2**N_IN bits have been accepted, it returns to RUN and pulses cfg_done.
REQ-018 SHALL, in LOAD, shift cfg_bit into the table register on each cfg_valid; cfg_valid outside LOAD is ignored.
REQ-019 SHALL, when cfg_start occurs during LOAD, restart the load (counter to 0, partial bits discarded).
REQ-020 SHALL, when cfg_start and in_valid occur in the same cycle in RUN, give cfg_start priority; in_ready is 0 that cycle.
REQ-021 SHALL let an already-registered output drain during LOAD; it is evaluated with the table active at capture.
REQ-022 SHALL use a bit counter of width N_IN+1 with no wrap: the terminal count 2**N_IN-1 with cfg_valid ends the load.

Reset
REQ-023 SHALL, while rst is high, force state=RUN, table=TT_INIT, out_valid=0, out_data=0, cfg_done=0, counter=0; in_ready is 1 in the first cycle after release.
REQ-024 SHALL, on rst during LOAD, abort the load and restore TT_INIT without pulsing cfg_done.

Configuration
REQ-025 SHALL support macro TT_LUT_SHADOW_EN.
REQ-026 SHALL, with TT_LUT_SHADOW_EN defined, shift loads into a shadow table, keep state RUN-capable (in_ready unaffected by LOAD), and copy shadow to active in the cycle cfg_done pulses; an operand accepted that same cycle uses the old table.
REQ-027 SHALL, without TT_LUT_SHADOW_EN, load the active table directly and block input (in_ready=0) throughout LOAD.

Structure
REQ-028 SHALL place state enum (RUN, LOAD) and max-N_IN constant in package tt_lut_pkg.
REQ-029 SHALL contain one sub-module, tt_lut_loader (state machine, bit counter, shift/shadow register); evaluation and output register stay in the top.

Verification
REQ-030 SHALL verify that after reset with defaults, in_data=0,1,2,3 back-to-back with out_ready=1 yields out_data=1,0,1,0 each 1 cycle later.
REQ-031 SHALL verify that loading 16'hFFFF (16 cfg_valid bits of 1) yields cfg_done on the cycle after the 16th bit, and then in_data=4'h5 gives out_data=1.
REQ-032 SHALL verify that out_ready=0 for 3 cycles with in_valid=1 stalls in_ready=0 and holds out_data; on release, no operand is lost or duplicated.
REQ-033 SHALL verify that cfg_start after 7 bits restarts the load: a further 16 bits are required and only the final 16 are used.
REQ-034 SHALL verify that rst asserted mid-load restores 0xA960 (in_data=0 gives 1) and produces no cfg_done.
REQ-035 SHALL verify that, with TT_LUT_SHADOW_EN, evaluations during a load use the old table, and the new table takes effect starting with the operand accepted the cycle after cfg_done.
